mem_xbar: RTL and testbench
===========================

MEM_XBAR -- requirements
Module: mem_xbar

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_MASTERS, 2, number of core-side request ports.
- N_BANKS, 2, number of single-port SRAM banks.
- DATA_WIDTH, 32, data width in bits; byte enables are DATA_WIDTH/8 wide.
- BANK_SIZE, 32768, bytes per bank; must be a power of two.
- BASE_ADDR, 32'h1000_0000, byte address of bank 0; must be aligned to BANK_SIZE.
- BANK_AW, $clog2(BANK_SIZE), width of the bank byte address.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- m_req_i, in, N_MASTERS, request valid per master.
- m_gnt_o, out, N_MASTERS, request accepted this cycle.
- m_rvalid_o, out, N_MASTERS, response valid.
- m_err_o, out, N_MASTERS, response is a decode error; qualified by m_rvalid_o.
- m_we_i, in, N_MASTERS, write enable.
- m_be_i, in, N_MASTERS*DATA_WIDTH/8, byte enables.
- m_addr_i, in, N_MASTERS*32, byte address.
- m_wdata_i, in, N_MASTERS*DATA_WIDTH, write data.
- m_rdata_o, out, N_MASTERS*DATA_WIDTH, read data.
- b_en_o, out, N_BANKS, bank access strobe.
- b_we_o, out, N_BANKS, bank write enable.
- b_be_o, out, N_BANKS*DATA_WIDTH/8, bank byte enables.
- b_addr_o, out, N_BANKS*BANK_AW, byte address within the bank.
- b_wdata_o, out, N_BANKS*DATA_WIDTH, bank write data.
- b_rdata_i, in, N_BANKS*DATA_WIDTH, bank read data, valid the cycle after b_en_o.
REQ-003 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.

Function
REQ-004 Master protocol SHALL be req/gnt/rvalid: the master holds req, addr, we, be and wdata stable until gnt; gnt is combinational in the same cycle; exactly one rvalid follows in cycle T+1 for each gnt in cycle T, for reads and for writes.
REQ-005 Decode SHALL use off = addr - BASE_ADDR (32-bit unsigned); the access is in range iff off < N_BANKS*BANK_SIZE.
REQ-006 For an in-range access, the bank index SHALL be off / BANK_SIZE and the bank address SHALL be off[BANK_AW-1:0], passed unmodified with no word alignment.
REQ-007 Each bank SHALL run an independent round-robin arbiter over the masters decoding to it, with a priority pointer p.
REQ-008 The arbiter SHALL grant the first requester at index p, p+1, ... mod N_MASTERS.
REQ-009 On a grant to master k, the arbiter SHALL set p to (k+1) mod N_MASTERS; p SHALL be unchanged when that bank grants nothing.
REQ-010 A granted access SHALL drive b_en_o=1 and the winner's we, be, addr and wdata onto that bank in the same cycle; an idle bank SHALL drive b_en_o=0 and b_we_o=0.
REQ-011 A losing master SHALL see gnt=0 and be retried in later cycles with no state recorded for it.
REQ-012 An out-of-range request SHALL be granted immediately without arbitration and SHALL touch no bank.
REQ-013 The response to an out-of-range request SHALL, in the next cycle, be rvalid=1, err=1 and rdata=0.
REQ-014 Per master, the block SHALL register rsp_valid, rsp_err and rsp_bank on gnt; m_rdata_o SHALL be b_rdata_i[rsp_bank] combinationally when rsp_valid=1 and rsp_err=0, and 0 otherwise.
REQ-015 Back-to-back access SHALL be supported: a master granted in both T and T+1 receives rvalid in T+1 and in T+2, giving full throughput of one access per cycle per bank.
REQ-016 Distinct masters targeting distinct banks SHALL all be granted in the same cycle.
REQ-017 Writes SHALL return rvalid with m_rdata_o equal to the bank's rdata, which masters ignore; err=0.
REQ-018 With N_MASTERS=1 the arbiter SHALL degenerate to grant-when-requested.

Reset
REQ-019 While rst=1, the block SHALL hold all m_gnt_o, m_rvalid_o, m_err_o and b_en_o at 0, m_rdata_o at 0, and all p at 0.
REQ-020 A response pending when rst asserts SHALL be dropped: no rvalid appears for it after rst deasserts.
REQ-021 The first cycle after rst deasserts SHALL arbitrate normally, with master 0 highest priority on every bank.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Both masters read bank 0 continuously for 4 cycles after reset -> gnt order M0,M1,M0,M1; each rvalid 1 cycle after its gnt, with rdata = bank 0 contents.
- M0 writes 0xDEADBEEF to 0x1000_0004 with be=4'b0011 -> bank 0 gets en=1, we=1, addr=4, be=4'b0011 in the same cycle; M0 rvalid=1, err=0 at T+1.
- M0 accesses 0x1000_0000 while M1 accesses 0x1000_8000 in the same cycle -> both granted; bank 0 addr=0 and bank 1 addr=0.
- M1 reads 0x2000_0000 -> gnt in the same cycle, no b_en_o; at T+1 rvalid=1, err=1, rdata=0.
- M0 granted in cycle T with rst=1 in T+1 -> no rvalid at T+1 or later; the first post-reset contention for a bank grants M0.
- M0 issues three consecutive reads to bank 1 with M1 idle -> gnt in 3 consecutive cycles and 3 consecutive rvalids, in order.

Source files
------------

// File: rtl/mem_xbar.sv
// Multi-master to multi-bank SRAM crossbar with per-bank round-robin arbitration.
// One-cycle req/gnt/rvalid protocol; out-of-range accesses complete with an error response.
module mem_xbar #(
   parameter int          N_MASTERS  = 2,
   parameter int          N_BANKS    = 2,
   parameter int          DATA_WIDTH = 32,
   parameter int          BANK_SIZE  = 32768,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          BANK_AW    = $clog2(BANK_SIZE)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_MASTERS-1:0]              m_req_i,
   output logic [N_MASTERS-1:0]              m_gnt_o,
   output logic [N_MASTERS-1:0]              m_rvalid_o,
   output logic [N_MASTERS-1:0]              m_err_o,
   input  logic [N_MASTERS-1:0]              m_we_i,
   input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
   input  logic [N_MASTERS*32-1:0]           m_addr_i,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
   output logic [N_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
   output logic [N_BANKS-1:0]                b_en_o,
   output logic [N_BANKS-1:0]                b_we_o,
   output logic [N_BANKS*DATA_WIDTH/8-1:0]   b_be_o,
   output logic [N_BANKS*BANK_AW-1:0]        b_addr_o,
   output logic [N_BANKS*DATA_WIDTH-1:0]     b_wdata_o,
   input  logic [N_BANKS*DATA_WIDTH-1:0]     b_rdata_i
);
   localparam int BE_W = DATA_WIDTH / 8;
   localparam int MW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int BW   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
   localparam logic [63:0] SPAN = 64'(N_BANKS) * 64'(BANK_SIZE);

   logic [N_MASTERS-1:0] req;
   logic [31:0]          off      [N_MASTERS];
   logic [N_MASTERS-1:0] in_range;
   logic [BW-1:0]        bank_sel [N_MASTERS];

   logic [MW-1:0]        prio     [N_BANKS];
   logic [N_BANKS-1:0]   win_valid;
   logic [MW-1:0]        win_idx  [N_BANKS];

   logic [N_MASTERS-1:0] rsp_valid;
   logic [N_MASTERS-1:0] rsp_err;
   logic [BW-1:0]        rsp_bank [N_MASTERS];

   // Masking requests during reset keeps every grant and bank strobe low.
   assign req = m_req_i & {N_MASTERS{~rst}};

   always_comb begin
      for (int m = 0; m < N_MASTERS; m++) begin
         off[m]      = m_addr_i[m*32 +: 32] - BASE_ADDR;
         in_range[m] = {32'd0, off[m]} < SPAN;
         bank_sel[m] = BW'(off[m] >> BANK_AW);
      end
   end

   // Scan masters starting at the bank's priority pointer; first hit wins.
   always_comb begin
      int k;
      k = 0;
      for (int b = 0; b < N_BANKS; b++) begin
         win_valid[b] = 1'b0;
         win_idx[b]   = '0;
         for (int i = 0; i < N_MASTERS; i++) begin
            k = (int'(prio[b]) + i) % N_MASTERS;
            if (!win_valid[b] && req[k] && in_range[k] && (bank_sel[k] == BW'(b))) begin
               win_valid[b] = 1'b1;
               win_idx[b]   = MW'(k);
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < N_BANKS; b++) begin
         b_en_o[b]                          = win_valid[b];
         b_we_o[b]                          = win_valid[b] & m_we_i[win_idx[b]];
         b_be_o[b*BE_W +: BE_W]             = m_be_i[int'(win_idx[b])*BE_W +: BE_W];
         b_addr_o[b*BANK_AW +: BANK_AW]     = off[win_idx[b]][BANK_AW-1:0];
         b_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[int'(win_idx[b])*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      for (int m = 0; m < N_MASTERS; m++) begin
         if (!req[m]) begin
            m_gnt_o[m] = 1'b0;
         end else if (!in_range[m]) begin
            m_gnt_o[m] = 1'b1;
         end else begin
            m_gnt_o[m] = win_valid[bank_sel[m]] && (win_idx[bank_sel[m]] == MW'(m));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_err   <= '0;
         for (int m = 0; m < N_MASTERS; m++) rsp_bank[m] <= '0;
         for (int b = 0; b < N_BANKS; b++) prio[b] <= '0;
      end else begin
         rsp_valid <= m_gnt_o;
         rsp_err   <= m_gnt_o & ~in_range;
         for (int m = 0; m < N_MASTERS; m++) begin
            if (m_gnt_o[m] && in_range[m]) rsp_bank[m] <= bank_sel[m];
         end
         for (int b = 0; b < N_BANKS; b++) begin
            if (win_valid[b]) begin
               prio[b] <= (win_idx[b] == MW'(N_MASTERS - 1)) ? '0 : win_idx[b] + 1'b1;
            end
         end
      end
   end

   // A response registered just before reset is suppressed while rst is high.
   always_comb begin
      m_rvalid_o = rsp_valid & {N_MASTERS{~rst}};
      m_err_o    = rsp_valid & rsp_err & {N_MASTERS{~rst}};
      for (int m = 0; m < N_MASTERS; m++) begin
         if (rsp_valid[m] && !rsp_err[m] && !rst) begin
            m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = b_rdata_i[int'(rsp_bank[m])*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_xbar.sv
// Bench for mem_xbar: SRAM bank emulation, a transaction-level reference model,
// directed scenarios and a randomized contention run.
module tb_mem_xbar;
   localparam int NM = 2, NB = 2, DW = 32, BEW = 4, BS = 32768, AW = 15, WORDS = BS / 4;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst;
   logic [NM-1:0] m_req, m_gnt, m_rvalid, m_err, m_we;
   logic [NM*BEW-1:0] m_be;
   logic [NM*32-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata, m_rdata;
   logic [NB-1:0] b_en, b_we;
   logic [NB*BEW-1:0] b_be;
   logic [NB*AW-1:0] b_addr;
   logic [NB*DW-1:0] b_wdata, b_rdata;

   int total = 0;
   int bad = 0;

   logic        init_en;
   logic [31:0] sram    [NB][WORDS];
   logic [31:0] ref_mem [NB][WORDS];
   int          prio [NB];
   logic [NM-1:0] pend_v, pend_err, pend_rd;
   logic [31:0] pend_data [NM];

   logic [NM-1:0] exp_gnt, exp_rvalid, exp_err, exp_chk;
   logic [31:0]   exp_rdata [NM];
   logic [NB-1:0] exp_en;
   int            exp_win [NB];

   mem_xbar dut (
      .clk(clk), .rst(rst),
      .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_err_o(m_err),
      .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
      .b_en_o(b_en), .b_we_o(b_we), .b_be_o(b_be), .b_addr_o(b_addr),
      .b_wdata_o(b_wdata), .b_rdata_i(b_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int b, input int w);
      return (32'(b) * 32'h9E37_79B9) ^ (32'(w) * 32'h85EB_CA6B) ^ 32'h1234_5678;
   endfunction

   // Single-port SRAM banks: registered read, byte-enabled write.
   always @(posedge clk) begin
      if (init_en) begin
         for (int b = 0; b < NB; b++)
            for (int w = 0; w < WORDS; w++) sram[b][w] <= init_val(b, w);
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (b_en[b]) begin
               b_rdata[b*DW +: DW] <= sram[b][b_addr[b*AW+2 +: AW-2]];
               for (int i = 0; i < BEW; i++)
                  if (b_we[b] && b_be[b*BEW+i])
                     sram[b][b_addr[b*AW+2 +: AW-2]][8*i +: 8] <= b_wdata[b*DW+8*i +: 8];
            end
         end
      end
   end

   // Drives one cycle and derives the expected outputs for it from the access rules.
   task automatic drive_cycle(input logic r, input logic [NM-1:0] req, input logic [NM-1:0] we,
                              input logic [NM*BEW-1:0] be, input logic [NM*32-1:0] addr,
                              input logic [NM*DW-1:0] wdata);
      logic [31:0] offs [NM];
      logic [NM-1:0] inr;
      int bk [NM];
      int best, bestd, d, w;
      @(posedge clk);
      #1;
      rst = r; m_req = req; m_we = we; m_be = be; m_addr = addr; m_wdata = wdata;
      for (int m = 0; m < NM; m++) begin
         exp_rvalid[m] = !r && pend_v[m];
         exp_err[m]    = !r && pend_v[m] && pend_err[m];
         exp_chk[m]    = !(exp_rvalid[m] && !exp_err[m] && !pend_rd[m]);
         exp_rdata[m]  = (exp_rvalid[m] && !exp_err[m]) ? pend_data[m] : 32'd0;
         offs[m] = addr[m*32 +: 32] - BASE;
         inr[m]  = offs[m] < 32'(NB * BS);
         bk[m]   = int'(offs[m] / BS);
      end
      exp_gnt = '0;
      exp_en  = '0;
      for (int b = 0; b < NB; b++) exp_win[b] = -1;
      if (r) begin
         for (int b = 0; b < NB; b++) prio[b] = 0;
         pend_v = '0; pend_err = '0; pend_rd = '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            best = -1; bestd = NM;
            for (int m = 0; m < NM; m++) begin
               if (req[m] && inr[m] && bk[m] == b) begin
                  d = (m - prio[b] + NM) % NM;
                  if (d < bestd) begin bestd = d; best = m; end
               end
            end
            exp_win[b] = best;
            if (best >= 0) begin
               exp_en[b] = 1'b1;
               exp_gnt[best] = 1'b1;
               prio[b] = (best + 1) % NM;
            end
         end
         for (int m = 0; m < NM; m++) if (req[m] && !inr[m]) exp_gnt[m] = 1'b1;
         for (int m = 0; m < NM; m++) begin
            pend_data[m] = 32'd0;
            if (exp_gnt[m] && inr[m]) pend_data[m] = ref_mem[bk[m]][int'(offs[m][AW-1:2])];
         end
         for (int m = 0; m < NM; m++) begin
            if (exp_gnt[m] && inr[m] && we[m]) begin
               w = int'(offs[m][AW-1:2]);
               for (int i = 0; i < BEW; i++)
                  if (be[m*BEW+i]) ref_mem[bk[m]][w][8*i +: 8] = wdata[m*DW+8*i +: 8];
            end
         end
         pend_v = exp_gnt; pend_err = exp_gnt & ~inr; pend_rd = ~we;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive_cycle(1'b1, 2'b11, 2'b00, 8'hFF, {BASE, BASE}, '0);
      total++; if (m_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", m_gnt); end
      total++; if (b_en !== 2'b00) begin bad++; $display("FAIL reset_ben got=%b want=00", b_en); end
      total++; if (m_rvalid !== 2'b00 || m_err !== 2'b00) begin bad++; $display("FAIL reset_rsp rvalid=%b err=%b want=00", m_rvalid, m_err); end
      total++; if (m_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", m_rdata); end
   endtask

   task automatic test_contention();
      logic [NM-1:0] order [4];
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
      for (int c = 0; c < 5; c++) begin
         if (c < 4) drive_cycle(1'b0, 2'b11, 2'b00, 8'hFF, {BASE + 32'd12, BASE + 32'd8}, '0);
         else drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
         if (c < 4) begin
            total++; if (m_gnt !== order[c]) begin bad++; $display("FAIL contention_gnt c=%0d got=%b want=%b", c, m_gnt, order[c]); end
         end
         if (c > 0) begin
            total++; if (m_rvalid !== order[c-1]) begin bad++; $display("FAIL contention_rvalid c=%0d got=%b want=%b", c, m_rvalid, order[c-1]); end
            for (int m = 0; m < NM; m++) begin
               total++;
               if (m_rdata[m*DW +: DW] !== exp_rdata[m]) begin
                  bad++; $display("FAIL contention_rdata c=%0d m=%0d got=%h want=%h", c, m, m_rdata[m*DW +: DW], exp_rdata[m]);
               end
            end
         end
      end
   endtask

   task automatic test_write();
      logic [31:0] old, want;
      old = init_val(0, 1);
      want = {old[31:16], 16'hBEEF};
      drive_cycle(1'b0, 2'b01, 2'b01, 8'h03, {32'd0, 32'h1000_0004}, {32'd0, 32'hDEAD_BEEF});
      total++; if (m_gnt[0] !== 1'b1) begin bad++; $display("FAIL write_gnt got=%b want=1", m_gnt[0]); end
      total++;
      if (b_en[0] !== 1'b1 || b_we[0] !== 1'b1 || b_addr[AW-1:0] !== 15'd4 || b_be[3:0] !== 4'b0011 || b_wdata[31:0] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL write_bank en=%b we=%b addr=%h be=%b wdata=%h want 1 1 4 0011 deadbeef", b_en[0], b_we[0], b_addr[AW-1:0], b_be[3:0], b_wdata[31:0]);
      end
      drive_cycle(1'b0, 2'b01, 2'b00, 8'h0F, {32'd0, 32'h1000_0004}, '0);
      total++; if (m_rvalid[0] !== 1'b1 || m_err[0] !== 1'b0) begin bad++; $display("FAIL write_rsp rvalid=%b err=%b want 1 0", m_rvalid[0], m_err[0]); end
      drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
      total++; if (m_rdata[31:0] !== want) begin bad++; $display("FAIL write_readback got=%h want=%h", m_rdata[31:0], want); end
   endtask

   task automatic test_parallel();
      drive_cycle(1'b0, 2'b11, 2'b00, 8'hFF, {32'h1000_8000, 32'h1000_0000}, '0);
      total++; if (m_gnt !== 2'b11 || b_en !== 2'b11) begin bad++; $display("FAIL parallel_gnt gnt=%b en=%b want 11 11", m_gnt, b_en); end
      total++; if (b_addr !== '0) begin bad++; $display("FAIL parallel_addr got=%h want=0", b_addr); end
      drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
      total++; if (m_rdata[31:0] !== init_val(0, 0) || m_rdata[63:32] !== init_val(1, 0)) begin
         bad++; $display("FAIL parallel_rdata got=%h want=%h%h", m_rdata, init_val(1, 0), init_val(0, 0));
      end
   endtask

   task automatic test_decode_err();
      drive_cycle(1'b0, 2'b10, 2'b00, 8'hF0, {32'h2000_0000, 32'd0}, '0);
      total++; if (m_gnt !== 2'b10 || b_en !== 2'b00) begin bad++; $display("FAIL decode_gnt gnt=%b en=%b want 10 00", m_gnt, b_en); end
      drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
      total++;
      if (m_rvalid[1] !== 1'b1 || m_err[1] !== 1'b1 || m_rdata[63:32] !== 32'd0) begin
         bad++; $display("FAIL decode_rsp rvalid=%b err=%b rdata=%h want 1 1 0", m_rvalid[1], m_err[1], m_rdata[63:32]);
      end
   endtask

   task automatic test_reset_drop();
      drive_cycle(1'b0, 2'b01, 2'b00, 8'h0F, {32'd0, 32'h1000_8010}, '0);
      total++; if (m_gnt !== 2'b01) begin bad++; $display("FAIL drop_pre_gnt got=%b want=01", m_gnt); end
      drive_cycle(1'b1, 2'b00, 2'b00, 8'h00, '0, '0);
      total++; if (m_rvalid !== 2'b00) begin bad++; $display("FAIL drop_in_reset rvalid=%b want=00", m_rvalid); end
      drive_cycle(1'b0, 2'b11, 2'b00, 8'hFF, {32'h1000_8020, 32'h1000_8024}, '0);
      total++; if (m_gnt !== 2'b01) begin bad++; $display("FAIL drop_post_prio got=%b want=01", m_gnt); end
      total++; if (m_rvalid !== 2'b00) begin bad++; $display("FAIL drop_post_rvalid got=%b want=00", m_rvalid); end
      drive_cycle(1'b0, 2'b10, 2'b00, 8'hF0, {32'h1000_8020, 32'd0}, '0);
      total++; if (m_gnt !== 2'b10 || m_rvalid !== 2'b01) begin bad++; $display("FAIL drop_follow gnt=%b rvalid=%b want 10 01", m_gnt, m_rvalid); end
      drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) begin
         if (c < 3) drive_cycle(1'b0, 2'b01, 2'b00, 8'h0F, {32'd0, 32'h1000_8000 + 32'(4 * (c + 5))}, '0);
         else drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
         total++;
         if (m_gnt !== ((c < 3) ? 2'b01 : 2'b00) || m_rvalid !== ((c > 0) ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL b2b_handshake c=%0d gnt=%b rvalid=%b", c, m_gnt, m_rvalid);
         end
         if (c > 0) begin
            total++;
            if (m_rdata[31:0] !== init_val(1, c + 4)) begin
               bad++; $display("FAIL b2b_rdata c=%0d got=%h want=%h", c, m_rdata[31:0], init_val(1, c + 4));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [NM-1:0] act, we;
      logic [NM*BEW-1:0] be;
      logic [NM*32-1:0] addr;
      logic [NM*DW-1:0] wdata;
      logic r;
      logic [31:0] o;
      int w;
      act = '0; we = '0; be = '0; addr = '0; wdata = '0;
      for (int c = 0; c < 400; c++) begin
         for (int m = 0; m < NM; m++) begin
            if (!act[m] && $urandom_range(0, 9) < 7) begin
               act[m] = 1'b1;
               we[m] = 1'($urandom_range(0, 1));
               be[m*BEW +: BEW] = 4'($urandom_range(0, 15));
               wdata[m*DW +: DW] = $urandom;
               if ($urandom_range(0, 9) == 0) addr[m*32 +: 32] = ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : BASE + 32'(NB * BS) + 32'($urandom_range(0, 255));
               else addr[m*32 +: 32] = BASE + 32'($urandom_range(0, NB - 1) * BS) + 32'($urandom_range(0, 31));
            end
         end
         r = ($urandom_range(0, 49) == 0);
         drive_cycle(r, act, we, be, addr, wdata);
         total++; if (m_gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, m_gnt, exp_gnt); end
         total++; if (m_rvalid !== exp_rvalid || m_err !== exp_err) begin bad++; $display("FAIL rnd_rsp c=%0d rvalid=%b/%b err=%b/%b", c, m_rvalid, exp_rvalid, m_err, exp_err); end
         total++; if (b_en !== exp_en) begin bad++; $display("FAIL rnd_ben c=%0d got=%b want=%b", c, b_en, exp_en); end
         for (int m = 0; m < NM; m++) begin
            if (exp_chk[m]) begin
               total++;
               if (m_rdata[m*DW +: DW] !== exp_rdata[m]) begin
                  bad++; $display("FAIL rnd_rdata c=%0d m=%0d got=%h want=%h", c, m, m_rdata[m*DW +: DW], exp_rdata[m]);
               end
            end
         end
         for (int b = 0; b < NB; b++) begin
            if (exp_win[b] >= 0) begin
               w = exp_win[b];
               o = addr[w*32 +: 32] - BASE;
               total++;
               if (b_we[b] !== we[w] || b_addr[b*AW +: AW] !== o[AW-1:0] || b_be[b*BEW +: BEW] !== be[w*BEW +: BEW] || b_wdata[b*DW +: DW] !== wdata[w*DW +: DW]) begin
                  bad++; $display("FAIL rnd_bank c=%0d b=%0d we=%b addr=%h be=%b wdata=%h winner=%0d", c, b, b_we[b], b_addr[b*AW +: AW], b_be[b*BEW +: BEW], b_wdata[b*DW +: DW], w);
               end
            end
         end
         act = act & ~exp_gnt;
      end
      drive_cycle(1'b0, 2'b00, 2'b00, 8'h00, '0, '0);
   endtask

   initial begin
      rst = 1'b1; m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
      init_en = 1'b1;
      for (int b = 0; b < NB; b++) begin
         prio[b] = 0;
         for (int w = 0; w < WORDS; w++) ref_mem[b][w] = init_val(b, w);
      end
      pend_v = '0; pend_err = '0; pend_rd = '0;
      for (int m = 0; m < NM; m++) pend_data[m] = 32'd0;
      @(posedge clk);
      #1 init_en = 1'b0;
      test_reset();
      test_contention();
      test_write();
      test_parallel();
      test_decode_err();
      test_reset_drop();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
